// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: PC next-address select encodings and FSM states.
package interrupt_controller_pkg;

  localparam int unsigned PC_SEL_W = 3;
  localparam int unsigned N_LEVELS = 2;

  localparam logic [PC_SEL_W-1:0] PC_NEXTX_NEXT  = 3'd0;
  localparam logic [PC_SEL_W-1:0] PC_NEXTX_INTV0 = 3'd4;
  localparam logic [PC_SEL_W-1:0] PC_NEXTX_INTV1 = 3'd5;
  localparam logic [PC_SEL_W-1:0] PC_NEXTX_INTR0 = 3'd6;
  localparam logic [PC_SEL_W-1:0] PC_NEXTX_INTR1 = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TAKE0 = 3'd1,
    ST_TAKE1 = 3'd2,
    ST_RET0  = 3'd3,
    ST_RET1  = 3'd4
  } intc_state_e;

endpackage

// File: rtl/interrupt_controller_if.sv
// Core-side bus between pipeline/decoder, interrupt controller and program counter.
import interrupt_controller_pkg::*;

interface interrupt_controller_if;
  logic                FETCH;
  logic                DECODE;
  logic                COMMIT;
  logic                INTC_EIX;
  logic                INTC_DIX;
  logic                INTC_RETIX;
  logic [PC_SEL_W-1:0] PC_NEXTX_DEC;
  logic                PC_ENX_DEC;
  logic [PC_SEL_W-1:0] PC_NEXTX;
  logic                PC_ENX;
  logic                PC_LD_INT0X;
  logic                PC_LD_INT1X;

  // Core/decoder side
  modport master (
    output FETCH, DECODE, COMMIT, INTC_EIX, INTC_DIX, INTC_RETIX, PC_NEXTX_DEC, PC_ENX_DEC,
    input  PC_NEXTX, PC_ENX, PC_LD_INT0X, PC_LD_INT1X
  );

  // Interrupt controller side
  modport slave (
    input  FETCH, DECODE, COMMIT, INTC_EIX, INTC_DIX, INTC_RETIX, PC_NEXTX_DEC, PC_ENX_DEC,
    output PC_NEXTX, PC_ENX, PC_LD_INT0X, PC_LD_INT1X
  );
endinterface

// File: rtl/interrupt_controller_intc_sync.sv
// Per-level request synchroniser; with INTC_EDGE_DETECT_EN defined the output is a
// one-cycle rising-edge pulse, otherwise it is the synchronised level.
module intc_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic req_in,
  output logic req_out
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
  end

`ifdef INTC_EDGE_DETECT_EN
  logic last_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) last_q <= 1'b0;
    else       last_q <= sync_q[SYNC_STAGES-1];
  end

  assign req_out = sync_q[SYNC_STAGES-1] & ~last_q;
`else
  assign req_out = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/interrupt_controller.sv
// Two-level interrupt controller that overrides PC next-address control at instruction boundaries.
// Define INTC_EDGE_DETECT_EN for edge-latched requests; default is level-sensitive.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   INT0_IN,
  input  logic                   INT1_IN,
  interrupt_controller_if.slave  bus,
  output logic [N_LEVELS-1:0]    INT_ACK,
  output logic                   INT_EN,
  output logic [N_LEVELS-1:0]    IN_SERVICE
);

  intc_state_e         state_q;
  logic                ie_q;
  logic [N_LEVELS-1:0] isr_q;
  logic [N_LEVELS-1:0] ack_q;
  logic [N_LEVELS-1:0] req;
  logic [N_LEVELS-1:0] pend;
  logic                unused_decode;

  assign unused_decode = bus.DECODE;

  intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
    .CLK(CLK), .RESET(RESET), .req_in(INT0_IN), .req_out(req[0])
  );

  intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .CLK(CLK), .RESET(RESET), .req_in(INT1_IN), .req_out(req[1])
  );

`ifdef INTC_EDGE_DETECT_EN
  logic [N_LEVELS-1:0] pend_q;
  logic [N_LEVELS-1:0] pend_clr;

  assign pend_clr = {bus.FETCH && (state_q == ST_TAKE1), bus.FETCH && (state_q == ST_TAKE0)};

  // Clear wins on the taking edge; a fresh edge re-arms from the next cycle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pend_q <= '0;
    else       pend_q <= (pend_q | req) & ~pend_clr;
  end

  assign pend = pend_q;
`else
  assign pend = req;
`endif

  // Boundary FSM plus IE/ISR/ACK registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ie_q    <= 1'b0;
      isr_q   <= '0;
      ack_q   <= '0;
    end else begin
      ack_q <= '0;
      if (bus.COMMIT) begin
        if (bus.INTC_EIX)      ie_q <= 1'b1;
        else if (bus.INTC_DIX) ie_q <= 1'b0;
        if (state_q == ST_IDLE) begin
          if (bus.INTC_RETIX && isr_q[0])                    state_q <= ST_RET0;
          else if (bus.INTC_RETIX && isr_q[1])               state_q <= ST_RET1;
          else if (ie_q && pend[0] && !isr_q[0])             state_q <= ST_TAKE0;
          else if (ie_q && pend[1] && !isr_q[0] && !isr_q[1]) state_q <= ST_TAKE1;
        end
      end
      if (bus.FETCH && (state_q != ST_IDLE)) begin
        state_q <= ST_IDLE;
        case (state_q)
          ST_TAKE0: begin isr_q[0] <= 1'b1; ack_q <= 2'b01; end
          ST_TAKE1: begin isr_q[1] <= 1'b1; ack_q <= 2'b10; end
          ST_RET0:  isr_q[0] <= 1'b0;
          ST_RET1:  isr_q[1] <= 1'b0;
          default:  ;
        endcase
      end
    end
  end

  // PC control mux: overrides the decoder only in the FETCH cycle after a decision
  always_comb begin
    bus.PC_NEXTX    = bus.PC_NEXTX_DEC;
    bus.PC_ENX      = bus.PC_ENX_DEC;
    bus.PC_LD_INT0X = 1'b0;
    bus.PC_LD_INT1X = 1'b0;
    if (bus.FETCH) begin
      case (state_q)
        ST_TAKE0: begin bus.PC_NEXTX = PC_NEXTX_INTV0; bus.PC_ENX = 1'b1; bus.PC_LD_INT0X = 1'b1; end
        ST_TAKE1: begin bus.PC_NEXTX = PC_NEXTX_INTV1; bus.PC_ENX = 1'b1; bus.PC_LD_INT1X = 1'b1; end
        ST_RET0:  begin bus.PC_NEXTX = PC_NEXTX_INTR0; bus.PC_ENX = 1'b1; end
        ST_RET1:  begin bus.PC_NEXTX = PC_NEXTX_INTR1; bus.PC_ENX = 1'b1; end
        default:  ;
      endcase
    end
  end

  assign INT_ACK    = ack_q;
  assign INT_EN     = ie_q;
  assign IN_SERVICE = isr_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed testbench for interrupt_controller: phase rotation, vectoring, nesting, RETI and reset.
module tb_interrupt_controller;
  import interrupt_controller_pkg::*;

  localparam logic [2:0] DEC_SEL = 3'd1;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       INT0_IN;
  logic       INT1_IN;
  logic [1:0] INT_ACK;
  logic       INT_EN;
  logic [1:0] IN_SERVICE;

  interrupt_controller_if bus();

  interrupt_controller #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .INT0_IN(INT0_IN), .INT1_IN(INT1_IN), .bus(bus),
    .INT_ACK(INT_ACK), .INT_EN(INT_EN), .IN_SERVICE(IN_SERVICE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int ph = 0;
  bit auto_drop = 1'b1;
  int ack0_cnt = 0;

  task automatic drive_phase();
    bus.FETCH  = (ph == 0);
    bus.DECODE = (ph == 1);
    bus.COMMIT = (ph == 2);
  endtask

  // One clock: rotate phase, clear decode strobes, model device dropping request on ACK
  task automatic tick();
    @(posedge CLK);
    #1;
    ph = (ph + 1) % 3;
    drive_phase();
    bus.INTC_EIX = 1'b0;
    bus.INTC_DIX = 1'b0;
    bus.INTC_RETIX = 1'b0;
    if (INT_ACK[0]) begin
      ack0_cnt++;
      if (auto_drop) INT0_IN = 1'b0;
    end
    if (INT_ACK[1] && auto_drop) INT1_IN = 1'b0;
    #1;
  endtask

  task automatic to_phase(input int p);
    for (int i = 0; i < 3 && ph != p; i++) tick();
  endtask

  task automatic wait_vector(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.FETCH && (bus.PC_LD_INT0X || bus.PC_LD_INT1X)) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(); tick();
    checks++; if (INT_EN !== 1'b0) begin errors++; $display("FAIL reset_ie: got %b want 0", INT_EN); end
    checks++; if (IN_SERVICE !== 2'b00) begin errors++; $display("FAIL reset_isr: got %b want 00", IN_SERVICE); end
    checks++; if (INT_ACK !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", INT_ACK); end
    checks++; if (bus.PC_NEXTX !== DEC_SEL || bus.PC_ENX !== 1'b1) begin
      errors++; $display("FAIL reset_pass: got %0d/%b want %0d/1", bus.PC_NEXTX, bus.PC_ENX, DEC_SEL); end
    checks++; if ({bus.PC_LD_INT1X, bus.PC_LD_INT0X} !== 2'b00) begin
      errors++; $display("FAIL reset_ld: got %b want 00", {bus.PC_LD_INT1X, bus.PC_LD_INT0X}); end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_take();
    bit found;
    to_phase(2);
    bus.INTC_EIX = 1'b1;
    tick();
    checks++; if (INT_EN !== 1'b1) begin errors++; $display("FAIL ei_set: got %b want 1", INT_EN); end
    INT0_IN = 1'b1;
    wait_vector(found);
    checks++; if (!found || bus.PC_NEXTX !== PC_NEXTX_INTV0) begin
      errors++; $display("FAIL midtake_vec: got found=%b sel=%0d want 1/%0d", found, bus.PC_NEXTX, PC_NEXTX_INTV0); end
    RESET = 1'b1;
    #1;
    checks++; if (bus.PC_NEXTX !== DEC_SEL || bus.PC_LD_INT0X !== 1'b0) begin
      errors++; $display("FAIL midtake_pass: got %0d/%b want %0d/0", bus.PC_NEXTX, bus.PC_LD_INT0X, DEC_SEL); end
    INT0_IN = 1'b0;
    tick();
    checks++; if (INT_ACK !== 2'b00 || IN_SERVICE !== 2'b00 || INT_EN !== 1'b0) begin
      errors++; $display("FAIL midtake_rst: got ack=%b isr=%b ie=%b want 00/00/0", INT_ACK, IN_SERVICE, INT_EN); end
    RESET = 1'b0;
    tick(); tick(); tick();
    checks++; if (INT_ACK !== 2'b00 || IN_SERVICE !== 2'b00) begin
      errors++; $display("FAIL midtake_after: got ack=%b isr=%b want 00/00", INT_ACK, IN_SERVICE); end
  endtask

  task automatic test_pend_then_ei();
    int vec_seen = 0;
    INT0_IN = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.FETCH && (bus.PC_LD_INT0X || bus.PC_LD_INT1X)) vec_seen++;
    end
    checks++; if (vec_seen != 0) begin errors++; $display("FAIL ie0_novec: got %0d vectors want 0", vec_seen); end
    to_phase(2);
    bus.INTC_EIX = 1'b1;
    tick();
    checks++; if (bus.PC_NEXTX !== DEC_SEL || bus.PC_LD_INT0X !== 1'b0 || INT_EN !== 1'b1) begin
      errors++; $display("FAIL ei_oldie: got sel=%0d ld=%b ie=%b want %0d/0/1", bus.PC_NEXTX, bus.PC_LD_INT0X, INT_EN, DEC_SEL); end
    tick(); tick(); tick();
    checks++; if (bus.PC_NEXTX !== PC_NEXTX_INTV0 || bus.PC_ENX !== 1'b1 || bus.PC_LD_INT0X !== 1'b1) begin
      errors++; $display("FAIL ei_vec: got sel=%0d en=%b ld=%b want %0d/1/1", bus.PC_NEXTX, bus.PC_ENX, bus.PC_LD_INT0X, PC_NEXTX_INTV0); end
    tick();
    checks++; if (INT_ACK !== 2'b01 || IN_SERVICE !== 2'b01) begin
      errors++; $display("FAIL ei_ack: got ack=%b isr=%b want 01/01", INT_ACK, IN_SERVICE); end
    to_phase(2);
    bus.INTC_RETIX = 1'b1;
    tick();
    checks++; if (bus.PC_NEXTX !== PC_NEXTX_INTR0 || bus.PC_ENX !== 1'b1 || {bus.PC_LD_INT1X, bus.PC_LD_INT0X} !== 2'b00) begin
      errors++; $display("FAIL reti0: got sel=%0d en=%b want %0d/1 no ld", bus.PC_NEXTX, bus.PC_ENX, PC_NEXTX_INTR0); end
    tick();
    checks++; if (IN_SERVICE !== 2'b00) begin errors++; $display("FAIL reti0_isr: got %b want 00", IN_SERVICE); end
  endtask

  task automatic test_simultaneous();
    bit found;
    INT0_IN = 1'b1;
    INT1_IN = 1'b1;
    wait_vector(found);
    checks++; if (!found || bus.PC_NEXTX !== PC_NEXTX_INTV0 || bus.PC_LD_INT1X !== 1'b0) begin
      errors++; $display("FAIL simul_first: got found=%b sel=%0d want 1/%0d", found, bus.PC_NEXTX, PC_NEXTX_INTV0); end
    tick();
    checks++; if (INT_ACK !== 2'b01 || IN_SERVICE !== 2'b01) begin
      errors++; $display("FAIL simul_ack0: got ack=%b isr=%b want 01/01", INT_ACK, IN_SERVICE); end
    to_phase(2);
    bus.INTC_RETIX = 1'b1;
    tick();
    checks++; if (bus.PC_NEXTX !== PC_NEXTX_INTR0) begin
      errors++; $display("FAIL simul_reti: got %0d want %0d", bus.PC_NEXTX, PC_NEXTX_INTR0); end
    tick();
    checks++; if (IN_SERVICE !== 2'b00) begin errors++; $display("FAIL simul_isr0: got %b want 00", IN_SERVICE); end
    wait_vector(found);
    checks++; if (!found || bus.PC_NEXTX !== PC_NEXTX_INTV1 || bus.PC_LD_INT1X !== 1'b1) begin
      errors++; $display("FAIL simul_second: got found=%b sel=%0d want 1/%0d", found, bus.PC_NEXTX, PC_NEXTX_INTV1); end
    tick();
    checks++; if (INT_ACK !== 2'b10 || IN_SERVICE !== 2'b10) begin
      errors++; $display("FAIL simul_ack1: got ack=%b isr=%b want 10/10", INT_ACK, IN_SERVICE); end
  endtask

  task automatic test_nesting();
    bit found;
    INT0_IN = 1'b1;
    wait_vector(found);
    checks++; if (!found || bus.PC_NEXTX !== PC_NEXTX_INTV0) begin
      errors++; $display("FAIL nest_vec: got found=%b sel=%0d want 1/%0d", found, bus.PC_NEXTX, PC_NEXTX_INTV0); end
    tick();
    checks++; if (IN_SERVICE !== 2'b11) begin errors++; $display("FAIL nest_isr: got %b want 11", IN_SERVICE); end
    to_phase(2);
    bus.INTC_RETIX = 1'b1;
    tick();
    checks++; if (bus.PC_NEXTX !== PC_NEXTX_INTR0) begin
      errors++; $display("FAIL nest_ret0: got %0d want %0d", bus.PC_NEXTX, PC_NEXTX_INTR0); end
    tick();
    checks++; if (IN_SERVICE !== 2'b10) begin errors++; $display("FAIL nest_isr10: got %b want 10", IN_SERVICE); end
    to_phase(2);
    bus.INTC_RETIX = 1'b1;
    tick();
    checks++; if (bus.PC_NEXTX !== PC_NEXTX_INTR1) begin
      errors++; $display("FAIL nest_ret1: got %0d want %0d", bus.PC_NEXTX, PC_NEXTX_INTR1); end
    tick();
    checks++; if (IN_SERVICE !== 2'b00) begin errors++; $display("FAIL nest_isr00: got %b want 00", IN_SERVICE); end
  endtask

  task automatic test_held_pending();
    bit found;
    int vec_seen = 0;
    INT1_IN = 1'b1;
    wait_vector(found);
    checks++; if (!found || bus.PC_NEXTX !== PC_NEXTX_INTV1) begin
      errors++; $display("FAIL hold_take1: got found=%b sel=%0d want 1/%0d", found, bus.PC_NEXTX, PC_NEXTX_INTV1); end
    tick();
    tick(); tick(); tick();
    INT1_IN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.FETCH && (bus.PC_LD_INT0X || bus.PC_LD_INT1X)) vec_seen++;
    end
    checks++; if (vec_seen != 0 || IN_SERVICE !== 2'b10) begin
      errors++; $display("FAIL hold_masked: got vectors=%0d isr=%b want 0/10", vec_seen, IN_SERVICE); end
    to_phase(2);
    bus.INTC_RETIX = 1'b1;
    tick();
    checks++; if (bus.PC_NEXTX !== PC_NEXTX_INTR1) begin
      errors++; $display("FAIL hold_ret1: got %0d want %0d", bus.PC_NEXTX, PC_NEXTX_INTR1); end
    wait_vector(found);
    checks++; if (!found || bus.PC_NEXTX !== PC_NEXTX_INTV1) begin
      errors++; $display("FAIL hold_retake: got found=%b sel=%0d want 1/%0d", found, bus.PC_NEXTX, PC_NEXTX_INTV1); end
    tick();
    to_phase(2);
    bus.INTC_RETIX = 1'b1;
    tick(); tick();
    checks++; if (IN_SERVICE !== 2'b00) begin errors++; $display("FAIL hold_clean: got %b want 00", IN_SERVICE); end
  endtask

  task automatic test_reti_idle();
    bus.PC_NEXTX_DEC = 3'd3;
    bus.PC_ENX_DEC = 1'b0;
    to_phase(2);
    bus.INTC_RETIX = 1'b1;
    tick();
    checks++; if (bus.PC_NEXTX !== 3'd3 || bus.PC_ENX !== 1'b0 || {bus.PC_LD_INT1X, bus.PC_LD_INT0X} !== 2'b00) begin
      errors++; $display("FAIL reti_idle: got sel=%0d en=%b want 3/0 no ld", bus.PC_NEXTX, bus.PC_ENX); end
    tick();
    checks++; if (IN_SERVICE !== 2'b00 || INT_ACK !== 2'b00) begin
      errors++; $display("FAIL reti_idle_st: got isr=%b ack=%b want 00/00", IN_SERVICE, INT_ACK); end
    bus.PC_NEXTX_DEC = DEC_SEL;
    bus.PC_ENX_DEC = 1'b1;
  endtask

  task automatic test_held_level();
    auto_drop = 1'b0;
    ack0_cnt = 0;
    INT0_IN = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    checks++; if (ack0_cnt != 1 || IN_SERVICE !== 2'b01) begin
      errors++; $display("FAIL held_once: got acks=%0d isr=%b want 1/01", ack0_cnt, IN_SERVICE); end
`ifdef INTC_EDGE_DETECT_EN
    to_phase(2);
    bus.INTC_RETIX = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    checks++; if (ack0_cnt != 1 || IN_SERVICE !== 2'b00) begin
      errors++; $display("FAIL held_noreentry: got acks=%0d isr=%b want 1/00", ack0_cnt, IN_SERVICE); end
    INT0_IN = 1'b0;
`else
    to_phase(2);
    bus.INTC_RETIX = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    checks++; if (ack0_cnt != 2 || IN_SERVICE !== 2'b01) begin
      errors++; $display("FAIL held_reentry: got acks=%0d isr=%b want 2/01", ack0_cnt, IN_SERVICE); end
    INT0_IN = 1'b0;
    to_phase(2);
    bus.INTC_RETIX = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (ack0_cnt != 2 || IN_SERVICE !== 2'b00) begin
      errors++; $display("FAIL held_release: got acks=%0d isr=%b want 2/00", ack0_cnt, IN_SERVICE); end
`endif
    auto_drop = 1'b1;
  endtask

  initial begin
    RESET = 1'b1;
    INT0_IN = 1'b0;
    INT1_IN = 1'b0;
    bus.INTC_EIX = 1'b0;
    bus.INTC_DIX = 1'b0;
    bus.INTC_RETIX = 1'b0;
    bus.PC_NEXTX_DEC = DEC_SEL;
    bus.PC_ENX_DEC = 1'b1;
    drive_phase();
    test_reset();
    test_reset_mid_take();
    test_pend_then_ei();
    test_simultaneous();
    test_nesting();
    test_held_pending();
    test_reti_idle();
    test_held_level();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
